uart_transmitter: RTL
=====================

// Module: uart_transmitter
// PURPOSE
//   Serialises one byte per ready/valid handshake onto an asynchronous UART line,
//   using 8N1 framing, LSB first, with the line idling high.
//   Forms the outbound half of the serial link. Inbound serial data enters the
//   design through the 2-FF synchronizer.
//   serial_out is driven straight from a flop, so the output has no glitches.
// PARAMETERS
//   CLOCK_FREQ  125_000_000  clk frequency in Hz
//   BAUD_RATE   115_200      line rate in bits/s
//   (local) SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE, integer division. This is
//   clk cycles per bit and must be >= 2. Counter width = $clog2(SYMBOL_EDGE_TIME).
// PORTS
//   clk            in   1  system clock; all state updates on rising edge
//   reset          in   1  asynchronous, active-high reset
//   data_in        in   8  byte to transmit; sampled only on the handshake cycle
//   data_in_valid  in   1  producer has a byte on data_in
//   data_in_ready  out  1  transmitter idle and able to accept a byte
//   serial_out     out  1  UART line (1 = idle/mark)
// BEHAVIOUR
//   - Reset, asynchronous on assertion: serial_out=1, state=IDLE, counters=0.
//     data_in_ready=1 once reset is low. No handshake is accepted while reset=1.
//   - States: IDLE -> SEND -> IDLE.
//   - IDLE: data_in_ready=1 (decoded from state), serial_out=1.
//   - Handshake: data_in_valid && data_in_ready at a rising edge. On that edge:
//     - load shift reg {1'b1, data_in, 1'b0};
//     - go to SEND;
//     - serial_out falls to 0 (start bit).
//   - SEND:
//     - data_in_ready=0.
//     - Each of 10 symbols (start, d0..d7, stop) is held exactly SYMBOL_EDGE_TIME cycles.
//     - Clock counter counts 0..SYMBOL_EDGE_TIME-1. On wrap: shift right one bit,
//       bit counter increments.
//     - After the 10th symbol completes, return to IDLE. The line stays 1.
//   - Frame length: 10*SYMBOL_EDGE_TIME cycles from handshake edge to IDLE.
//   - data_in and data_in_valid are ignored during SEND. The byte is captured once.
//   - Back-to-back: data_in_ready is high for at least 1 cycle between frames.
//     Held valid starts the next start bit on that IDLE cycle's edge, so the stop
//     bit lasts SYMBOL_EDGE_TIME+1 cycles. No other inter-frame gap is inserted.
//   - Reset mid-frame: line returns high immediately and the frame is abandoned.
//     The byte is not retransmitted. A normal handshake is possible the first
//     edge after reset deasserts.
//   - serial_out never shows X after reset. With data_in_valid stuck low, the line
//     stays 1 indefinitely.
// TESTING  (bench uses CLOCK_FREQ=1000, BAUD_RATE=100 -> SYMBOL_EDGE_TIME=10)
//   1. Assert reset 3 cycles, release -> serial_out=1 and data_in_ready=1 throughout;
//      no activity for 50 idle cycles.
//   2. Send 8'hA5 -> sampling at mid-bit (cycle 5 of each 10) gives
//      0,1,0,1,0,0,1,0,1,1. data_in_ready is low for exactly 100 cycles.
//   3. During frame of 8'h3C, toggle data_in/data_in_valid randomly ->
//      line still carries 8'h3C; nothing extra is accepted.
//   4. Hold valid, send 8'h00 then 8'hFF back-to-back -> second start bit begins
//      101 cycles after first handshake; both bytes decode correctly.
//   5. Assert reset 35 cycles into a frame of 8'h00 -> serial_out=1 asynchronously
//      (before next edge). After release, 8'h81 transmits correctly.
//   6. Scoreboard: a reference UART receiver model decodes 256 random bytes
//      sent with random valid gaps -> all 256 bytes match, in order.

Source files
------------

// File: rtl/uart_transmitter.sv
// UART transmitter: one byte per ready/valid handshake, 8N1 framing,
// LSB first, line idles high. serial_out comes straight from a flop.
module uart_transmitter #(
  parameter int unsigned CLOCK_FREQ = 125_000_000,
  parameter int unsigned BAUD_RATE  = 115_200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       data_in_valid,
  output logic       data_in_ready,
  output logic       serial_out
);

  // Clock cycles per symbol; must be at least 2.
  localparam int unsigned SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
  localparam int unsigned CNT_W            = $clog2(SYMBOL_EDGE_TIME);
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(SYMBOL_EDGE_TIME - 1);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] clk_cnt;
  logic [3:0]       bit_cnt;
  // Start bit is driven directly on the handshake edge, so only data and
  // stop bit are held here; the register shifts in ones behind them.
  logic [8:0]       shift_reg;

  // Ready is decoded from state and held low while reset is asserted.
  assign data_in_ready = (state == IDLE) && !reset;

  // Frame sequencer: handshake, symbol timing, shifting and line drive.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      clk_cnt    <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '1;
      serial_out <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          serial_out <= 1'b1;
          if (data_in_valid) begin
            shift_reg  <= {1'b1, data_in};
            serial_out <= 1'b0;
            clk_cnt    <= '0;
            bit_cnt    <= '0;
            state      <= SEND;
          end
        end
        SEND: begin
          if (clk_cnt == CNT_LAST) begin
            clk_cnt <= '0;
            if (bit_cnt == 4'd9) begin
              bit_cnt    <= '0;
              serial_out <= 1'b1;
              state      <= IDLE;
            end else begin
              bit_cnt    <= bit_cnt + 4'd1;
              serial_out <= shift_reg[0];
              shift_reg  <= {1'b1, shift_reg[8:1]};
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          serial_out <= 1'b1;
        end
      endcase
    end
  end

endmodule
